// File: rtl/core_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_arbiter
// Brief    : Round-robin arbiter sharing one word-wide bridge slave port,
//            with a watchdog that forces an SLVERR on stalled transfers.
// Revision : 1.0
// ============================================================================
module core_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [32*NUM_MASTERS-1:0] m_bus_addr,
    input  logic [NUM_MASTERS-1:0]    m_bus_read,
    input  logic [NUM_MASTERS-1:0]    m_bus_write,
    input  logic [32*NUM_MASTERS-1:0] m_bus_writedata,
    input  logic [4*NUM_MASTERS-1:0]  m_bus_byteenable,
    output logic [NUM_MASTERS-1:0]    m_bus_waitrequest,
    output logic [32*NUM_MASTERS-1:0] m_bus_readdata,
    output logic [2*NUM_MASTERS-1:0]  m_bus_response,
    output logic [31:0]               s_bus_addr,
    output logic                      s_bus_read,
    output logic                      s_bus_write,
    output logic [31:0]               s_bus_writedata,
    output logic [3:0]                s_bus_byteenable,
    input  logic                      s_bus_waitrequest,
    input  logic [31:0]               s_bus_readdata,
    input  logic [1:0]                s_bus_response,
    output logic [NUM_MASTERS-1:0]    grant,
    output logic                      timeout_pulse
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_CNT_W-1:0] TO_LAST =
        TO_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [NUM_MASTERS-1:0] grant_d;
    logic [IDX_W-1:0]       last_q;
    logic [IDX_W-1:0]       gidx;
    logic [IDX_W-1:0]       cand;
    logic [TO_CNT_W-1:0]    cnt_q;
    logic [NUM_MASTERS-1:0] req;
    logic                   pick_vld;
    logic                   busy;
    logic                   sel_rd;
    logic                   sel_wr;
    logic                   sel_req;
    logic                   done;
    logic                   to_hit;
    logic [31:0]            sel_addr;
    logic [31:0]            sel_wdata;
    logic [3:0]             sel_be;

    assign req  = m_bus_read | m_bus_write;
    assign busy = (state_q == ST_BUSY);

    // Scan starts one past the last served master so every holder is reached within N grants.
    always_comb begin
        pick_vld = 1'b0;
        grant_d  = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = IDX_W'((int'(last_q) + k) % NUM_MASTERS);
            if (!pick_vld && req[cand]) begin
                pick_vld      = 1'b1;
                grant_d[cand] = 1'b1;
            end
        end
    end

    always_comb begin
        gidx      = '0;
        sel_rd    = 1'b0;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                gidx      = IDX_W'(i);
                sel_rd    = m_bus_read[i];
                sel_wr    = m_bus_write[i];
                sel_addr  = m_bus_addr[32*i +: 32];
                sel_wdata = m_bus_writedata[32*i +: 32];
                sel_be    = m_bus_byteenable[4*i +: 4];
            end
        end
    end

    // A genuine completion in the last watchdog cycle takes precedence over the timeout.
    assign sel_req = busy & (sel_rd | sel_wr);
    assign done    = sel_req & ~s_bus_waitrequest;
    assign to_hit  = TO_EN & sel_req & ~done & (cnt_q == TO_LAST);

    assign s_bus_read       = busy & sel_rd & ~to_hit;
    assign s_bus_write      = busy & sel_wr & ~to_hit;
    assign s_bus_addr       = busy ? sel_addr  : 32'h0;
    assign s_bus_writedata  = busy ? sel_wdata : 32'h0;
    assign s_bus_byteenable = busy ? sel_be    : 4'h0;
    assign timeout_pulse    = to_hit;
    assign grant            = grant_q;

    generate
        for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
            assign m_bus_waitrequest[i]      = ~(grant_q[i] & (done | to_hit));
            assign m_bus_readdata[32*i +: 32] = (grant_q[i] & done) ? s_bus_readdata : 32'h0;
            assign m_bus_response[2*i +: 2]   = (grant_q[i] & done)   ? s_bus_response :
                                                (grant_q[i] & to_hit) ? 2'b10 : 2'b00;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (pick_vld) begin
                        grant_q <= grant_d;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!sel_req) begin
                        // Requester abandoned the transfer: no response, fairness pointer untouched.
                        grant_q <= '0;
                        state_q <= ST_IDLE;
                    end else if (done || to_hit) begin
                        last_q  <= gidx;
                        grant_q <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + TO_CNT_W'(1);
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
